frame_move_scheduler: RTL and testbench

FRAME_MOVE_SCHEDULER -- requirements
Module: frame_move_scheduler

---
 rtl/move_sched_pkg.sv | 22 ++
 rtl/lowest_set_picker.sv | 23 ++
 rtl/frame_move_scheduler.sv | 136 +++++++++++++
 tb/tb_frame_move_scheduler.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/move_sched_pkg.sv
// Shared types and constants for the frame move scheduler.
package move_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_DONE,
    S_NEXT,
    S_PAUSED
  } sched_state_t;

  localparam int NUM_OBJ_DEFAULT = 4;
  localparam int TIMEOUT_DEFAULT = 1024;
  localparam int OVERRUN_W       = 8;
  localparam int FRAME_W         = 16;

  // Width needed to hold an index/count below n, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lowest_set_picker.sv
// Finds the lowest set bit of a mask; valid is low when the mask is empty.
module lowest_set_picker #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] mask,
  output logic [W-1:0] idx,
  output logic         valid
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx   = W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_move_scheduler.sv
// Per-frame sequencer that grants position-update steps to enabled objects
// one at a time, waits for each to finish (with a timeout), and keeps
// frame and overrun statistics.
module frame_move_scheduler
  import move_sched_pkg::*;
#(
  parameter int NUM_OBJ        = NUM_OBJ_DEFAULT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic                          clk,
  input  logic                          resetN,
  input  logic                          startOfFrame,
  input  logic                          pause_req,
  input  logic [NUM_OBJ-1:0]            obj_enable,
  input  logic [NUM_OBJ-1:0]            obj_done,
  output logic [NUM_OBJ-1:0]            obj_go,
  output logic [idx_width(NUM_OBJ)-1:0] active_idx,
  output logic                          busy,
  output logic                          timeout_err,
  output logic [OVERRUN_W-1:0]          overrun_cnt,
  output logic [FRAME_W-1:0]            frame_cnt
);

  localparam int IDX_W = idx_width(NUM_OBJ);
  localparam int TO_W  = idx_width(TIMEOUT_CYCLES);

  sched_state_t state, next_state;

  logic [NUM_OBJ-1:0] pending;
  logic [NUM_OBJ-1:0] pick_mask;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  logic [TO_W-1:0]    to_cnt;

  logic start_seq;
  logic timeout_hit;
  logic frame_end;
  logic overrun_hit;

  // In IDLE the next grant comes straight from the enables being latched;
  // otherwise it comes from what is still pending this frame.
  assign pick_mask = (state == S_IDLE) ? obj_enable : pending;

  lowest_set_picker #(
    .N (NUM_OBJ),
    .W (IDX_W)
  ) u_picker (
    .mask  (pick_mask),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // State register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= S_IDLE;
    else         state <= next_state;
  end

  // Next-state logic plus the one-cycle event strobes that drive the datapath.
  always_comb begin
    next_state  = state;
    start_seq   = 1'b0;
    timeout_hit = 1'b0;
    frame_end   = 1'b0;
    overrun_hit = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (pause_req) begin
          next_state = S_PAUSED;
        end else if (startOfFrame) begin
          start_seq = 1'b1;
          if (pick_valid) next_state = S_ISSUE;
          else            frame_end  = 1'b1;
        end
      end
      S_ISSUE: begin
        next_state = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        // Done is checked first so it wins over a coincident timeout.
        if (obj_done[active_idx]) begin
          next_state = S_NEXT;
        end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 2)) begin
          timeout_hit = 1'b1;
          next_state  = S_NEXT;
        end
      end
      S_NEXT: begin
        if (pick_valid) begin
          next_state = S_ISSUE;
        end else begin
          next_state = S_IDLE;
          frame_end  = 1'b1;
        end
      end
      S_PAUSED: begin
        if (!pause_req) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
    if (startOfFrame &&
        (state == S_ISSUE || state == S_WAIT_DONE || state == S_NEXT))
      overrun_hit = 1'b1;
  end

  // Outputs decoded purely from registered state.
  always_comb begin
    busy   = (state == S_ISSUE) || (state == S_WAIT_DONE) || (state == S_NEXT);
    obj_go = (state == S_ISSUE) ? (NUM_OBJ'(1) << active_idx) : '0;
  end

  // Pending mask, grant index, timeout counter and statistics.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pending     <= '0;
      active_idx  <= '0;
      to_cnt      <= '0;
      timeout_err <= 1'b0;
      overrun_cnt <= '0;
      frame_cnt   <= '0;
    end else begin
      timeout_err <= timeout_hit;
      if (start_seq) pending <= obj_enable;
      if (state == S_ISSUE) begin
        pending <= pending & ~obj_go;
        to_cnt  <= '0;
      end
      if (state == S_WAIT_DONE) to_cnt <= to_cnt + TO_W'(1);
      if (next_state == S_ISSUE) active_idx <= pick_idx;
      if (frame_end) frame_cnt <= frame_cnt + FRAME_W'(1);
      if (overrun_hit && (overrun_cnt != '1))
        overrun_cnt <= overrun_cnt + OVERRUN_W'(1);
    end
  end

endmodule

// File: tb/tb_frame_move_scheduler.sv
// Self-checking bench for frame_move_scheduler: each frame's grant schedule
// is predicted up front from mask, done delays and timeout rules, then
// compared cycle by cycle against the DUT.
module tb_frame_move_scheduler;
  import move_sched_pkg::*;

  localparam int N  = 4;
  localparam int TO = 1024;
  localparam int NEVER = 5000;

  logic        clk = 1'b0;
  logic        resetN;
  logic        startOfFrame;
  logic        pause_req;
  logic [3:0]  obj_enable;
  logic [3:0]  obj_done;
  logic [3:0]  obj_go;
  logic [1:0]  active_idx;
  logic        busy;
  logic        timeout_err;
  logic [7:0]  overrun_cnt;
  logic [15:0] frame_cnt;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_frames = 16'd0;
  int          exp_overruns = 0;

  always #5 clk = ~clk;

  frame_move_scheduler #(
    .NUM_OBJ        (N),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .pause_req    (pause_req),
    .obj_enable   (obj_enable),
    .obj_done     (obj_done),
    .obj_go       (obj_go),
    .active_idx   (active_idx),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .overrun_cnt  (overrun_cnt),
    .frame_cnt    (frame_cnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".obj_go"},      32'(obj_go),      32'd0);
    checkOutput({tag, ".active_idx"},  32'(active_idx),  32'd0);
    checkOutput({tag, ".busy"},        32'(busy),        32'd0);
    checkOutput({tag, ".timeout_err"}, 32'(timeout_err), 32'd0);
    checkOutput({tag, ".overrun_cnt"}, 32'(overrun_cnt), 32'd0);
    checkOutput({tag, ".frame_cnt"},   32'(frame_cnt),   32'd0);
  endtask

  // One frame: SOF in relative cycle 0, then every cycle checked against the
  // predicted schedule. A delay >= TO means that object never reports done.
  task automatic applyStimulus(input logic [3:0] mask, input int d0, input int d1,
                               input int d2, input int d3, input bit spam,
                               input bit distract, input bit hold_pause);
    int dly [4];
    int go_t [4];
    int go_o [4];
    int done_t [4];
    int to_t [4];
    int n, nto, t, end_t, sofs, cur;
    logic [3:0] exp_go, done_v;
    bit exp_to, exp_busy;
    dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
    n = 0; nto = 0; t = 1;
    for (int i = 0; i < N; i++) begin
      done_t[i] = -1;
      if (mask[i]) begin
        go_t[n] = t;
        go_o[n] = i;
        n++;
        if (dly[i] <= TO - 1) begin
          done_t[i] = t + dly[i];
          t = t + dly[i] + 2;
        end else begin
          to_t[nto] = t + TO;
          nto++;
          t = t + TO + 1;
        end
      end
    end
    end_t = t;
    sofs  = 0;
    for (int c = 0; c <= end_t; c++) begin
      @(negedge clk);
      cur = -1;
      for (int k = 0; k < n; k++) if (c >= go_t[k]) cur = k;
      exp_go = (cur >= 0 && c == go_t[cur]) ? 4'(1 << go_o[cur]) : 4'b0000;
      exp_to = 1'b0;
      for (int k = 0; k < nto; k++) if (c == to_t[k]) exp_to = 1'b1;
      exp_busy = (n > 0) && (c >= 1) && (c < end_t);
      checkOutput("obj_go",      32'(obj_go),      32'(exp_go));
      checkOutput("timeout_err", 32'(timeout_err), 32'(exp_to));
      checkOutput("busy",        32'(busy),        32'(exp_busy));
      if (exp_busy && cur >= 0)
        checkOutput("active_idx", 32'(active_idx), 32'(go_o[cur]));
      if (c == 0) begin
        checkOutput("frame_cnt_pre",   32'(frame_cnt),   32'(exp_frames));
        checkOutput("overrun_cnt_pre", 32'(overrun_cnt), 32'(exp_overruns));
      end
      if (c == end_t) begin
        exp_frames   = exp_frames + 16'd1;
        exp_overruns = (exp_overruns + sofs > 255) ? 255 : exp_overruns + sofs;
        checkOutput("frame_cnt",   32'(frame_cnt),   32'(exp_frames));
        checkOutput("overrun_cnt", 32'(overrun_cnt), 32'(exp_overruns));
      end
      startOfFrame = (c == 0) ||
                     (spam && c >= 1 && c < end_t && ($urandom_range(0, 1) == 1));
      if (c >= 1 && startOfFrame) sofs++;
      done_v = 4'b0000;
      for (int i = 0; i < N; i++) if (done_t[i] == c) done_v[i] = 1'b1;
      if (distract && cur >= 0) begin
        done_v = done_v | (4'($urandom) & ~(4'b0001 << go_o[cur]));
        if (c == go_t[cur]) done_v[go_o[cur]] = 1'b1;
      end
      obj_done   = done_v;
      obj_enable = (c == 0) ? mask : 4'($urandom);
      pause_req  = hold_pause && (c >= 1);
    end
    startOfFrame = 1'b0;
    obj_done     = 4'b0000;
  endtask

  // Sits in (or enters) PAUSED with SOF pulses that must be ignored, then
  // releases pause and confirms the scheduler is idle and counters unchanged.
  task automatic pausedWindow(input bit first_sof);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("pause.obj_go", 32'(obj_go), 32'd0);
      checkOutput("pause.busy",   32'(busy),   32'd0);
      pause_req    = 1'b1;
      startOfFrame = (i == 0) ? first_sof : ($urandom_range(0, 1) == 1);
      obj_enable   = 4'b1111;
    end
    @(negedge clk);
    checkOutput("pause.obj_go", 32'(obj_go), 32'd0);
    pause_req    = 1'b0;
    startOfFrame = 1'b1;
    @(negedge clk);
    checkOutput("unpause.obj_go",      32'(obj_go),      32'd0);
    checkOutput("unpause.busy",        32'(busy),        32'd0);
    checkOutput("unpause.frame_cnt",   32'(frame_cnt),   32'(exp_frames));
    checkOutput("unpause.overrun_cnt", 32'(overrun_cnt), 32'(exp_overruns));
    startOfFrame = 1'b0;
  endtask

  // Resets the DUT while it waits on an object, then confirms silence.
  task automatic resetMidSequence();
    @(negedge clk);
    obj_enable   = 4'b0011;
    startOfFrame = 1'b1;
    obj_done     = 4'b0000;
    @(negedge clk);
    startOfFrame = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    checkOutput("pre_reset.busy", 32'(busy), 32'd1);
    resetN = 1'b0;
    #1;
    exp_frames   = 16'd0;
    exp_overruns = 0;
    checkResetValues("mid_reset");
    @(negedge clk);
    @(negedge clk);
    resetN = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("post_reset.obj_go", 32'(obj_go), 32'd0);
      checkOutput("post_reset.busy",   32'(busy),   32'd0);
    end
  endtask

  initial begin
    resetN       = 1'b0;
    startOfFrame = 1'b0;
    pause_req    = 1'b0;
    obj_enable   = 4'b0000;
    obj_done     = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    checkResetValues("reset");
    resetN = 1'b1;
    @(negedge clk);

    $display("[TB] three objects, done 3 cycles after each grant");
    applyStimulus(4'b1011, 3, 3, 3, 3, 1'b0, 1'b0, 1'b0);

    $display("[TB] stray done bits from other objects and in the grant cycle");
    applyStimulus(4'b0101, 5, 5, 5, 5, 1'b0, 1'b1, 1'b0);

    $display("[TB] single object never done, timeout");
    applyStimulus(4'b0001, NEVER, 1, 1, 1, 1'b0, 1'b0, 1'b0);

    $display("[TB] done on the last possible cycle beats timeout");
    applyStimulus(4'b0010, 1, TO - 1, 1, 1, 1'b0, 1'b0, 1'b0);

    $display("[TB] frame pulses while busy saturate overrun counter");
    applyStimulus(4'b0001, NEVER, 1, 1, 1, 1'b1, 1'b0, 1'b0);
    checkOutput("overrun_saturated", 32'(overrun_cnt), 32'd255);

    $display("[TB] empty enable mask");
    applyStimulus(4'b0000, 1, 1, 1, 1, 1'b0, 1'b0, 1'b0);

    $display("[TB] pause and SOF in the same idle cycle");
    pausedWindow(1'b1);
    applyStimulus(4'b1100, 2, 2, 1, 4, 1'b0, 1'b0, 1'b0);

    $display("[TB] pause raised mid-sequence");
    applyStimulus(4'b0111, 2, 6, 3, 1, 1'b0, 1'b0, 1'b1);
    pausedWindow(1'b0);

    $display("[TB] randomized frames");
    for (int f = 0; f < 30; f++) begin
      applyStimulus(4'($urandom), $urandom_range(1, 12), $urandom_range(1, 12),
                    $urandom_range(1, 12), $urandom_range(1, 12),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("[TB] reset during wait");
    resetMidSequence();
    applyStimulus(4'b1001, 4, 1, 1, 2, 1'b0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
